// File: rtl/adder_ctrl_pkg.sv
// Shared definitions for the adder-sharing arbiter: datapath width, requester ID
// width and FSM state encoding.
package adder_ctrl_pkg;

   localparam int WIDTH = 16;
   localparam int ID_W  = 1;

   // 2'd3 is never entered; the FSM treats it as IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Request/result handshake bundle between two requesters, one consumer and the
// shared-adder arbiter.
interface adder_share_arbiter_if;

   logic [1:0]                        req_valid;
   logic [1:0]                        req_ready;
   logic [adder_ctrl_pkg::WIDTH-1:0]  req0_a;
   logic [adder_ctrl_pkg::WIDTH-1:0]  req0_b;
   logic [adder_ctrl_pkg::WIDTH-1:0]  req1_a;
   logic [adder_ctrl_pkg::WIDTH-1:0]  req1_b;
   logic                              out_valid;
   logic                              out_ready;
   logic [adder_ctrl_pkg::ID_W-1:0]   out_id;
   logic [adder_ctrl_pkg::WIDTH-1:0]  out_sum;
   logic                              out_overflow;

   modport master (
      output req_valid, req0_a, req0_b, req1_a, req1_b, out_ready,
      input  req_ready, out_valid, out_id, out_sum, out_overflow
   );

   modport slave (
      input  req_valid, req0_a, req0_b, req1_a, req1_b, out_ready,
      output req_ready, out_valid, out_id, out_sum, out_overflow
   );

endinterface

// File: rtl/adder_16bit.sv
// 16-bit wrapping adder with signed-overflow flag; carry-out is not exposed.
module adder_16bit (
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic [15:0] sum,
   output logic        overflow
);

   assign sum      = A + B;
   assign overflow = (A[15] == B[15]) && (sum[15] != A[15]);

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one adder_16bit between two requesters, with a held
// result register and a saturating overflow-event counter.
module adder_share_arbiter
   import adder_ctrl_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int OVF_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   adder_share_arbiter_if.slave  bus,
   output logic [OVF_CNT_W-1:0]  ovf_count
);

   generate
      if (WIDTH != 16) begin : g_width_check
         $error("adder_share_arbiter: WIDTH must be 16 to match adder_16bit");
      end
   endgenerate

   localparam logic [OVF_CNT_W-1:0] OVF_MAX = '1;

   state_t              state_reg;
   logic [15:0]         a_reg;
   logic [15:0]         b_reg;
   logic [ID_W-1:0]     id_reg;
   logic                last_grant_reg;
   logic                out_valid_reg;
   logic [ID_W-1:0]     out_id_reg;
   logic [15:0]         out_sum_reg;
   logic                out_ovf_reg;
   logic [OVF_CNT_W-1:0] ovf_count_reg;

   logic                grant_valid;
   logic                grant;
   logic                state_idle;
   logic [15:0]         add_sum;
   logic                add_ovf;

   // On a tie the requester that did not win last time gets the adder.
   always_comb begin
      grant_valid = 1'b0;
      grant       = 1'b0;
      case (bus.req_valid)
         2'b01: begin grant_valid = 1'b1; grant = 1'b0;            end
         2'b10: begin grant_valid = 1'b1; grant = 1'b1;            end
         2'b11: begin grant_valid = 1'b1; grant = ~last_grant_reg; end
         default: ;
      endcase
   end

   assign state_idle    = (state_reg != CALC) && (state_reg != DONE);
   assign bus.req_ready = (state_idle && grant_valid) ? (grant ? 2'b10 : 2'b01) : 2'b00;

   adder_16bit u_adder (
      .A        (a_reg),
      .B        (b_reg),
      .sum      (add_sum),
      .overflow (add_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         a_reg          <= '0;
         b_reg          <= '0;
         id_reg         <= '0;
         last_grant_reg <= 1'b1;
         out_valid_reg  <= 1'b0;
         out_id_reg     <= '0;
         out_sum_reg    <= '0;
         out_ovf_reg    <= 1'b0;
         ovf_count_reg  <= '0;
      end else begin
         case (state_reg)
            CALC: begin
               out_sum_reg   <= add_sum;
               out_ovf_reg   <= add_ovf;
               out_id_reg    <= id_reg;
               out_valid_reg <= 1'b1;
               state_reg     <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_reg <= 1'b0;
                  state_reg     <= IDLE;
                  if (out_ovf_reg && (ovf_count_reg != OVF_MAX))
                     ovf_count_reg <= ovf_count_reg + 1'b1;
               end
            end
            default: begin
               // A grant always coincides with the granted requester's valid.
               if (grant_valid) begin
                  a_reg          <= grant ? bus.req1_a : bus.req0_a;
                  b_reg          <= grant ? bus.req1_b : bus.req0_b;
                  id_reg         <= grant;
                  last_grant_reg <= grant;
                  state_reg      <= CALC;
               end
            end
         endcase
      end
   end

   assign bus.out_valid    = out_valid_reg;
   assign bus.out_id       = out_id_reg;
   assign bus.out_sum      = out_sum_reg;
   assign bus.out_overflow = out_ovf_reg;
   assign ovf_count        = ovf_count_reg;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: directed vector table, randomized
// traffic against an arithmetic reference model, saturation and mid-flight reset.
module tb_adder_share_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] ovf_count;

   adder_share_arbiter_if bus ();

   adder_share_arbiter #(.WIDTH(16), .OVF_CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .ovf_count (ovf_count)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   txn    = 0;
   logic last_m;
   int   cnt_m;

   typedef struct {
      bit          do_rst;
      logic [1:0]  valid;
      logic [15:0] a0, b0, a1, b1;
      int          stall;
      logic        exp_id;
      logic [15:0] exp_sum;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (txn %0d)", name, act, exp, txn);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.req_valid = 2'b00;
      bus.out_ready = 1'b0;
      tick();
      tick();
      rst    = 1'b0;
      last_m = 1'b1;
      cnt_m  = 0;
      #1;
   endtask

   // Reference arithmetic on plain signed integers.
   function automatic void ref_add(input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] s, output logic o);
      int sa;
      sa = int'($signed(a)) + int'($signed(b));
      s  = sa[15:0];
      o  = (sa > 32767) || (sa < -32768);
   endfunction

   task automatic transact(input logic [1:0] v, input logic [15:0] a0, input logic [15:0] b0,
                           input logic [15:0] a1, input logic [15:0] b1, input int stall,
                           input logic eid, input logic [15:0] esum, input logic eovf);
      bus.req_valid = v;
      bus.req0_a    = a0;
      bus.req0_b    = b0;
      bus.req1_a    = a1;
      bus.req1_b    = b1;
      bus.out_ready = 1'b0;
      #1;
      chk("grant_ready", {30'd0, bus.req_ready}, eid ? 32'd2 : 32'd1);
      tick();
      bus.req_valid[eid] = 1'b0;
      #1;
      chk("calc_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("calc_req_ready", {30'd0, bus.req_ready}, 32'd0);
      tick();
      chk("out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("out_id", {31'd0, bus.out_id}, {31'd0, eid});
      chk("out_sum", {16'd0, bus.out_sum}, {16'd0, esum});
      chk("out_overflow", {31'd0, bus.out_overflow}, {31'd0, eovf});
      for (int s = 0; s < stall; s++) begin
         tick();
         chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
         chk("stall_sum", {16'd0, bus.out_sum}, {16'd0, esum});
         chk("stall_req_ready", {30'd0, bus.req_ready}, 32'd0);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      last_m = eid;
      if (eovf && cnt_m < 255) cnt_m++;
      #1;
      chk("retire_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("ovf_count", {24'd0, ovf_count}, cnt_m);
      $display("txn %0d: valid=%b id=%0d sum=0x%04h ovf=%0d stall=%0d ovf_count=%0d",
               txn, v, eid, bus.out_sum, bus.out_overflow, stall, ovf_count);
      txn++;
   endtask

   initial begin
      logic [1:0]  v;
      logic [15:0] a0, b0, a1, b1, es;
      logic        g, eo;

      vecs[0] = '{1'b0, 2'b01, 16'h0002, 16'h0002, 16'h0000, 16'h0000, 0, 1'b0, 16'h0004, 1'b0};
      vecs[1] = '{1'b0, 2'b10, 16'h0000, 16'h0000, 16'h0005, 16'hFFFE, 0, 1'b1, 16'h0003, 1'b0};
      vecs[2] = '{1'b1, 2'b11, 16'h7FFF, 16'h0002, 16'hFFFE, 16'hFFFE, 0, 1'b0, 16'h8001, 1'b1};
      vecs[3] = '{1'b0, 2'b10, 16'h7FFF, 16'h0002, 16'hFFFE, 16'hFFFE, 0, 1'b1, 16'hFFFC, 1'b0};
      vecs[4] = '{1'b0, 2'b11, 16'h0004, 16'h0000, 16'h0001, 16'h0001, 5, 1'b0, 16'h0004, 1'b0};
      vecs[5] = '{1'b0, 2'b01, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 1, 1'b0, 16'h7FFF, 1'b1};

      bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
      do_reset();
      chk("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_out_id", {31'd0, bus.out_id}, 32'd0);
      chk("rst_out_sum", {16'd0, bus.out_sum}, 32'd0);
      chk("rst_out_overflow", {31'd0, bus.out_overflow}, 32'd0);
      chk("rst_ovf_count", {24'd0, ovf_count}, 32'd0);

      foreach (vecs[i]) begin
         if (vecs[i].do_rst) do_reset();
         transact(vecs[i].valid, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
                  vecs[i].stall, vecs[i].exp_id, vecs[i].exp_sum, vecs[i].exp_ovf);
      end
      chk("ovf_after_table", {24'd0, ovf_count}, 32'd2);

      // Random traffic: grant and result come from the reference model.
      for (int i = 0; i < 200; i++) begin
         v  = 2'($urandom_range(1, 3));
         a0 = 16'($urandom); b0 = 16'($urandom);
         a1 = 16'($urandom); b1 = 16'($urandom);
         g  = (v == 2'b11) ? ~last_m : v[1];
         if (g) ref_add(a1, b1, es, eo);
         else   ref_add(a0, b0, es, eo);
         transact(v, a0, b0, a1, b1, int'($urandom_range(0, 2)), g, es, eo);
      end

      for (int i = 0; i < 300; i++)
         transact(2'b01, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 0, 1'b0, 16'h0000, 1'b1);
      chk("ovf_saturated", {24'd0, ovf_count}, 32'd255);

      // Reset while an op from requester 0 sits in CALC.
      bus.req_valid = 2'b01;
      bus.req0_a    = 16'h7FFF;
      bus.req0_b    = 16'h0001;
      #1;
      tick();
      rst           = 1'b1;
      bus.req_valid = 2'b00;
      tick();
      rst    = 1'b0;
      last_m = 1'b1;
      cnt_m  = 0;
      #1;
      chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("midrst_ovf_count", {24'd0, ovf_count}, 32'd0);
      chk("midrst_req_ready", {30'd0, bus.req_ready}, 32'd0);
      tick();
      chk("midrst_no_pulse", {31'd0, bus.out_valid}, 32'd0);
      transact(2'b11, 16'h0001, 16'h0001, 16'h0002, 16'h0002, 0, 1'b0, 16'h0002, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
